// File: rtl/imm_pkg.sv
// imm_pkg: shared definitions for the constant materialiser.
//   - RV32I opcode/funct3 constants used by LUI and ADDI
//   - FSM state encoding for imm_materialise
//   - form codes describing which instruction sequence rebuilds a constant
//   - encoder helpers for the two instruction formats
package imm_pkg;

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_OPIMM = 7'b0010011;
   localparam logic [2:0] F3_ADDI  = 3'b000;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      EMIT_LUI  = 2'd1,
      EMIT_ADDI = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      FORM_ADDI = 2'd0,
      FORM_LUI  = 2'd1,
      FORM_PAIR = 2'd2
   } form_e;

   // U-type LUI word
   function automatic logic [31:0] enc_lui(input logic [19:0] imm20, input logic [4:0] rd);
      return {imm20, rd, OP_LUI};
   endfunction

   // I-type ADDI word
   function automatic logic [31:0] enc_addi(input logic [11:0] imm12, input logic [4:0] rs1,
                                            input logic [4:0] rd);
      return {imm12, rs1, F3_ADDI, rd, OP_OPIMM};
   endfunction

endpackage

// File: rtl/imm_split.sv
// imm_split: combinational split of a 32-bit constant into LUI/ADDI immediates.
//   v     in   32  constant
//   hi    out  20  LUI immediate such that (hi<<12) + sext(lo) == v (mod 2^32)
//   lo    out  12  ADDI immediate (v[11:0], read as signed)
//   form  out      cheapest instruction sequence that rebuilds v
// SHORT_EN=0 forces the two-word form for every constant.
module imm_split
   import imm_pkg::*;
#(
   parameter int SHORT_EN = 1
) (
   input  logic [31:0] v,
   output logic [19:0] hi,
   output logic [11:0] lo,
   output form_e       form
);

   logic [31:0] rounded_s;
   logic        fits_s12_s;

   // Split and form selection; adding 0x800 pre-compensates the sign extension of lo.
   always_comb begin
      rounded_s  = v + 32'h0000_0800;
      hi         = rounded_s[31:12];
      lo         = v[11:0];
      // v fits a signed 12-bit immediate when bits 31..11 are all copies of the sign
      fits_s12_s = (v[31:11] == 21'h00_0000) || (v[31:11] == 21'h1F_FFFF);
      if ((SHORT_EN != 0) && fits_s12_s) begin
         form = FORM_ADDI;
      end else if ((SHORT_EN != 0) && (v[11:0] == 12'h000)) begin
         form = FORM_LUI;
      end else begin
         form = FORM_PAIR;
      end
   end

endmodule

// File: rtl/imm_materialise.sv
// imm_materialise: turns a 32-bit constant plus destination register into
// RV32I LUI / ADDI / LUI+ADDI instruction words.
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     request handshake; in_value constant, in_rd destination
//   out_valid/out_ready   word handshake; out_instr word, out_last marks final word
// A request with in_rd==0 is swallowed without emitting anything.
module imm_materialise
   import imm_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int RD_W     = 5,
   parameter int SHORT_EN = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_value,
   input  logic [RD_W-1:0]   in_rd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic              out_last
);

   state_e            state_q, state_d;
   form_e             form_q, form_d;
   logic [DATA_W-1:0] value_q, value_d;
   logic [RD_W-1:0]   rd_q, rd_d;
   logic              out_valid_q, out_valid_d;
   logic [31:0]       out_instr_q, out_instr_d;
   logic              out_last_q, out_last_d;

   logic [DATA_W-1:0] split_v_s;
   logic [19:0]       hi_s;
   logic [11:0]       lo_s;
   form_e             form_s;

   // In IDLE the splitter looks at the incoming constant so the first word can be
   // registered on acceptance; afterwards it works from the captured constant.
   always_comb begin
      if (state_q == IDLE) begin
         split_v_s = in_value;
      end else begin
         split_v_s = value_q;
      end
   end

   imm_split #(.SHORT_EN(SHORT_EN)) u_split (
      .v    (split_v_s),
      .hi   (hi_s),
      .lo   (lo_s),
      .form (form_s)
   );

   // Next-state and registered-output computation.
   always_comb begin
      state_d     = state_q;
      form_d      = form_q;
      value_d     = value_q;
      rd_d        = rd_q;
      out_valid_d = out_valid_q;
      out_instr_d = out_instr_q;
      out_last_d  = out_last_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               value_d = in_value;
               rd_d    = in_rd;
               form_d  = form_s;
               if (in_rd != {RD_W{1'b0}}) begin
                  out_valid_d = 1'b1;
                  case (form_s)
                     FORM_ADDI: begin
                        state_d     = EMIT_ADDI;
                        out_instr_d = enc_addi(lo_s, 5'd0, in_rd);
                        out_last_d  = 1'b1;
                     end
                     FORM_LUI: begin
                        state_d     = EMIT_LUI;
                        out_instr_d = enc_lui(hi_s, in_rd);
                        out_last_d  = 1'b1;
                     end
                     default: begin
                        state_d     = EMIT_LUI;
                        out_instr_d = enc_lui(hi_s, in_rd);
                        out_last_d  = 1'b0;
                     end
                  endcase
               end else begin
                  state_d = IDLE;
               end
            end else begin
               state_d = IDLE;
            end
         end
         EMIT_LUI: begin
            if (out_ready) begin
               if (form_q == FORM_PAIR) begin
                  state_d     = EMIT_ADDI;
                  out_instr_d = enc_addi(lo_s, rd_q, rd_q);
                  out_last_d  = 1'b1;
               end else begin
                  state_d     = IDLE;
                  out_valid_d = 1'b0;
                  out_instr_d = 32'h0000_0000;
                  out_last_d  = 1'b0;
               end
            end else begin
               state_d = EMIT_LUI;
            end
         end
         EMIT_ADDI: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               out_instr_d = 32'h0000_0000;
               out_last_d  = 1'b0;
            end else begin
               state_d = EMIT_ADDI;
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_instr_d = 32'h0000_0000;
            out_last_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset drops any request in flight immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         form_q      <= FORM_ADDI;
         value_q     <= {DATA_W{1'b0}};
         rd_q        <= {RD_W{1'b0}};
         out_valid_q <= 1'b0;
         out_instr_q <= 32'h0000_0000;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         form_q      <= form_d;
         value_q     <= value_d;
         rd_q        <= rd_d;
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         out_last_q  <= out_last_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign out_instr = out_instr_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_imm_materialise.sv
// tb_imm_materialise: random and directed checks of imm_materialise.
// Instance a uses SHORT_EN=1, instance b SHORT_EN=0. Emitted words are executed
// on a small register-file model and the result compared with the constant.
module tb_imm_materialise;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid_a = 1'b0, in_valid_b = 1'b0;
   logic [31:0] in_value = 32'h0;
   logic [4:0]  in_rd = 5'd0;
   logic        out_ready = 1'b0;

   logic        in_ready_a, out_valid_a, out_last_a;
   logic        in_ready_b, out_valid_b, out_last_b;
   logic [31:0] out_instr_a, out_instr_b;

   logic        sel = 1'b0;
   logic        cur_in_ready, cur_out_valid, cur_out_last;
   logic [31:0] cur_out_instr;

   int          n_checks = 0;
   int          n_pass = 0;
   logic [31:0] reg_model [32];
   logic [31:0] got_w [2];
   int          got_n;

   always #5 clk = ~clk;

   imm_materialise #(.DATA_W(32), .RD_W(5), .SHORT_EN(1)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .in_value(in_value), .in_rd(in_rd), .out_valid(out_valid_a),
      .out_ready(out_ready), .out_instr(out_instr_a), .out_last(out_last_a));

   imm_materialise #(.DATA_W(32), .RD_W(5), .SHORT_EN(0)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .in_value(in_value), .in_rd(in_rd), .out_valid(out_valid_b),
      .out_ready(out_ready), .out_instr(out_instr_b), .out_last(out_last_b));

   assign cur_in_ready  = sel ? in_ready_b  : in_ready_a;
   assign cur_out_valid = sel ? out_valid_b : out_valid_a;
   assign cur_out_last  = sel ? out_last_b  : out_last_a;
   assign cur_out_instr = sel ? out_instr_b : out_instr_a;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Number of words the constant needs, straight from the value's numeric range.
   function automatic int exp_words(input logic [31:0] v, input bit short_en);
      int signed sv;
      sv = v;
      if (short_en && sv >= -2048 && sv <= 2047) return 1;
      if (short_en && (v % 32'd4096) == 32'd0) return 1;
      return 2;
   endfunction

   // Execute one emitted word on the register-file model.
   task automatic exec_word(input logic [31:0] w);
      logic [4:0]  rd, rs1;
      logic [31:0] imm;
      rd  = w[11:7];
      rs1 = w[19:15];
      if (w[6:0] == 7'b0110111) begin
         reg_model[rd] = w[31:12] * 32'd4096;
      end else if (w[6:0] == 7'b0010011 && w[14:12] == 3'b000) begin
         imm = {{20{w[31]}}, w[31:20]};
         reg_model[rd] = reg_model[rs1] + imm;
      end else begin
         chk_eq("opcode_known", {25'd0, w[6:0]}, 32'h37);
      end
      reg_model[0] = 32'h0;
   endtask

   // Issue one request and collect its words, with optional stalls.
   task automatic send(input bit s, input logic [31:0] v, input logic [4:0] rd,
                       input int stall_pct, input int hold, input bit keep_valid);
      int          nexp;
      bit          done, held;
      logic [31:0] prev;
      @(negedge clk);
      sel = s;
      in_value = v;
      in_rd = rd;
      if (s) in_valid_b = 1'b1; else in_valid_a = 1'b1;
      chk_eq("in_ready_idle", {31'd0, cur_in_ready}, 32'd1);
      reg_model[rd] = $urandom();
      reg_model[0] = 32'h0;
      nexp = exp_words(v, !s);
      got_n = 0;
      got_w[0] = 32'h0;
      got_w[1] = 32'h0;
      @(posedge clk);
      @(negedge clk);
      if (!keep_valid) begin
         in_valid_a = 1'b0;
         in_valid_b = 1'b0;
      end
      if (rd == 5'd0) begin
         chk_eq("rd0_no_valid", {31'd0, cur_out_valid}, 32'd0);
         chk_eq("rd0_in_ready", {31'd0, cur_in_ready}, 32'd1);
         return;
      end
      chk_eq("latency1", {31'd0, cur_out_valid}, 32'd1);
      done = 1'b0;
      held = 1'b0;
      prev = 32'h0;
      for (int c = 0; c < 300 && !done; c++) begin
         if (c > 0) @(negedge clk);
         chk_eq("valid_held", {31'd0, cur_out_valid}, 32'd1);
         chk_eq("in_ready_busy", {31'd0, cur_in_ready}, 32'd0);
         if (held) chk_eq("instr_stable", cur_out_instr, prev);
         if (c < hold) out_ready = 1'b0;
         else out_ready = ($urandom_range(99) >= stall_pct);
         if (out_ready) begin
            if (got_n < 2) got_w[got_n] = cur_out_instr;
            got_n++;
            chk_eq("last_flag", {31'd0, cur_out_last}, {31'd0, (got_n == nexp)});
            exec_word(cur_out_instr);
            if (cur_out_last) done = 1'b1;
         end
         held = !out_ready;
         prev = cur_out_instr;
         @(posedge clk);
      end
      chk_eq("completed", {31'd0, done}, 32'd1);
      @(negedge clk);
      out_ready = 1'b0;
      in_valid_a = 1'b0;
      in_valid_b = 1'b0;
      chk_eq("word_count", got_n, nexp);
      chk_eq("reg_result", reg_model[rd], v);
      chk_eq("idle_after", {31'd0, cur_in_ready}, 32'd1);
      chk_eq("valid_after", {31'd0, cur_out_valid}, 32'd0);
   endtask

   logic [31:0] specials [8];

   initial begin
      specials[0] = 32'h0000_0000; specials[1] = 32'hFFFF_FFFF;
      specials[2] = 32'h8000_0000; specials[3] = 32'h0000_07FF;
      specials[4] = 32'h0000_0800; specials[5] = 32'hFFFF_F800;
      specials[6] = 32'h7FFF_F800; specials[7] = 32'h1234_57FF;

      // reset state
      #2;
      chk_eq("rst_in_ready", {31'd0, in_ready_a}, 32'd1);
      chk_eq("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
      chk_eq("rst_out_instr", out_instr_a, 32'h0);
      chk_eq("rst_out_last", {31'd0, out_last_a}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // directed encodings
      send(1'b0, 32'h0000_07FF, 5'd5, 0, 0, 1'b0);
      chk_eq("t1_word", got_w[0], 32'h7FF0_0293);
      send(1'b0, 32'h1234_5000, 5'd10, 0, 0, 1'b0);
      chk_eq("t2_word", got_w[0], 32'h1234_5537);
      send(1'b0, 32'h0000_0800, 5'd1, 0, 0, 1'b0);
      chk_eq("t3_lui", got_w[0], 32'h0000_10B7);
      chk_eq("t3_addi", got_w[1], 32'h8000_8093);
      send(1'b1, 32'h7FFF_F800, 5'd2, 0, 0, 1'b0);
      chk_eq("t4_lui", got_w[0], 32'h8000_0137);
      chk_eq("t4_addi", got_w[1], 32'h8001_0113);

      // backpressure with a second request held on in_valid, then rd=0
      send(1'b0, 32'hDEAD_BEEF, 5'd9, 0, 5, 1'b1);
      send(1'b0, 32'h0BAD_F00D, 5'd9, 0, 0, 1'b0);
      send(1'b0, 32'h1234_5678, 5'd0, 0, 0, 1'b0);

      // reset while presenting the ADDI word
      @(negedge clk);
      sel = 1'b0;
      in_value = 32'h1234_5678;
      in_rd = 5'd7;
      in_valid_a = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid_a = 1'b0;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk_eq("t6_in_addi", {31'd0, out_last_a}, 32'd1);
      rst = 1'b1;
      #1;
      chk_eq("t6_valid_drop", {31'd0, out_valid_a}, 32'd0);
      chk_eq("t6_instr_clr", out_instr_a, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_eq("t6_idle", {31'd0, in_ready_a}, 32'd1);
      chk_eq("t6_no_word", {31'd0, out_valid_a}, 32'd0);
      send(1'b0, 32'h1234_5678, 5'd7, 0, 0, 1'b0);

      // special values on both instances
      for (int i = 0; i < 8; i++) begin
         send(1'b0, specials[i], 5'($urandom_range(31, 1)), 40, 0, 1'b0);
         send(1'b1, specials[i], 5'($urandom_range(31, 1)), 40, 0, 1'b0);
      end

      // random constants, including crafted low-half edge patterns
      for (int i = 0; i < 60; i++) begin
         logic [31:0] v;
         logic [4:0]  rd;
         v = $urandom();
         case ($urandom_range(5))
            0: v = {v[31:12], 12'h7FF};
            1: v = {v[31:12], 12'h800};
            2: v = {v[31:12], 12'h000};
            3: v = {{21{v[11]}}, v[10:0]};
            default: v = v;
         endcase
         rd = ($urandom_range(9) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
         send(1'($urandom_range(1)), v, rd, 35, 0, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
